// File: rtl/rotate_ctrl.sv
// rotate_ctrl -- sequencer for one rotate pass over 64 slices x 25 lanes.
// Each slice is one READ, one LOAD, then 25 CALC/WRITE pairs (52 cycles),
// so a full pass keeps busy high for 3328 cycles, followed by one DONE cycle.
// Optional feature: define ROTATE_CTRL_STALL_EN to add a stall input that
// freezes the sequencer (state, counters and strobes) in its working states.
module rotate_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  output logic       slice_load,
  output logic [5:0] cnt64_value,
  output logic [4:0] cnt24_value,
  output logic       wr_en_1,
  output logic       wr_en_2,
  output logic       busy,
  output logic       done
`ifdef ROTATE_CTRL_STALL_EN
  ,
  input  logic       stall
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    CALC,
    WRITE,
    DONE
  } state_e;

  localparam logic [5:0] LAST_SLICE = 6'd63;
  localparam logic [4:0] LAST_LANE  = 5'd24;

  state_e     state_q;
  logic [5:0] cnt64_q;
  logic [4:0] cnt24_q;
  logic       active;
  logic       hold;

  // The four working states; busy and stall qualification both key off this.
  assign active = (state_q == READ) || (state_q == LOAD) ||
                  (state_q == CALC) || (state_q == WRITE);

`ifdef ROTATE_CTRL_STALL_EN
  // A stall only freezes the working states; IDLE and DONE run as normal.
  assign hold = stall & active;
`else
  assign hold = 1'b0;
`endif

  // State and slice/lane counters; reset wins over start and stall.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) on every register so each one samples the
    // pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt64_q <= '0;
      cnt24_q <= '0;
    end else if (!hold) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            cnt64_q <= '0;
            cnt24_q <= '0;
          end
        end
        READ:  state_q <= LOAD;   // one cycle of source-memory read latency
        LOAD:  state_q <= CALC;
        CALC:  state_q <= WRITE;
        WRITE: begin
          if (cnt24_q != LAST_LANE) begin
            cnt24_q <= cnt24_q + 5'd1;
            state_q <= CALC;
          end else if (cnt64_q != LAST_SLICE) begin
            cnt24_q <= '0;
            cnt64_q <= cnt64_q + 6'd1;
            state_q <= READ;
          end else begin
            // Counters keep (63, 24) until the next accepted start.
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;  // start is not looked at here
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes decoded from the registered state only; a stall masks the
  // strobe of the held state so it is issued exactly once on release.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    rd_en      = 1'b0;
    slice_load = 1'b0;
    wr_en_1    = 1'b0;
    wr_en_2    = 1'b0;
    done       = 1'b0;
    case (state_q)
      READ:    rd_en      = !hold;
      LOAD:    slice_load = !hold;
      CALC:    wr_en_1    = !hold;
      WRITE:   wr_en_2    = !hold;
      DONE:    done       = 1'b1;
      default: ;
    endcase
  end

  assign busy        = active;
  assign rd_addr     = cnt64_q;
  assign cnt64_value = cnt64_q;
  assign cnt24_value = cnt24_q;

`ifndef SYNTHESIS
  // Strobes are mutually exclusive and never fire outside a pass.
  a_strobe_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({rd_en, slice_load, wr_en_1, wr_en_2, done}));

  a_strobe_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (rd_en | slice_load | wr_en_1 | wr_en_2) |-> busy);

  // Lane index stays in 0..24.
  a_lane_range : assert property (@(posedge clk) disable iff (!rst_n)
    cnt24_q <= LAST_LANE);

  // The slice index never wraps back to 0 while a pass is running.
  a_slice_no_wrap : assert property (@(posedge clk) disable iff (!rst_n)
    (active && cnt64_q == LAST_SLICE) |=> !(active && cnt64_q == 6'd0));
`endif

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl. A scoreboard queue holds the expected strobe
// stream (kind, slice, lane, busy, read address); a monitor pops one entry
// per strobe and compares. Scenario tasks add cycle-level checks.
module tb_rotate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
`ifdef ROTATE_CTRL_STALL_EN
  logic       stall;
`endif
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       slice_load;
  logic [5:0] cnt64_value;
  logic [4:0] cnt24_value;
  logic       wr_en_1;
  logic       wr_en_2;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  rotate_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .slice_load  (slice_load),
    .cnt64_value (cnt64_value),
    .cnt24_value (cnt24_value),
    .wr_en_1     (wr_en_1),
    .wr_en_2     (wr_en_2),
    .busy        (busy),
    .done        (done)
`ifdef ROTATE_CTRL_STALL_EN
    ,
    .stall       (stall)
`endif
  );

  typedef enum logic [2:0] {EV_RD, EV_LD, EV_C1, EV_W2, EV_DN} ev_e;

  typedef struct packed {
    ev_e        kind;
    logic       busy;
    logic [5:0] z;
    logic [4:0] lane;
    logic [5:0] addr;
  } ev_t;

  ev_t  exp_q[$];
  int   rise_q[$];
  int   done_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_busy, n_rd, n_w1, n_w2, n_done;
  logic prev_busy = 1'b0;
  bit   mon_en    = 1'b0;

  function automatic ev_t mk(input ev_e k, input int z, input int l);
    ev_t e;
    e.kind = k;
    e.busy = (k != EV_DN);
    e.z    = 6'(z);
    e.lane = 5'(l);
    e.addr = (k == EV_RD) ? 6'(z) : 6'd0;
    return e;
  endfunction

  // Expected strobe stream of one pass; stops right after CALC(stop_z, stop_lane).
  task automatic push_pass(input int stop_z, input int stop_lane);
    for (int z = 0; z < 64; z++) begin
      exp_q.push_back(mk(EV_RD, z, 0));
      exp_q.push_back(mk(EV_LD, z, 0));
      for (int l = 0; l < 25; l++) begin
        exp_q.push_back(mk(EV_C1, z, l));
        if (z == stop_z && l == stop_lane) return;
        exp_q.push_back(mk(EV_W2, z, l));
      end
    end
    exp_q.push_back(mk(EV_DN, 63, 24));
  endtask

  task automatic reset_stats();
    n_busy = 0; n_rd = 0; n_w1 = 0; n_w2 = 0; n_done = 0;
    rise_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  // Scoreboard consumer and event counters, sampled on the falling edge.
  task automatic monitor();
    int  n;
    ev_t obs;
    ev_t want;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n = int'(rd_en) + int'(slice_load) + int'(wr_en_1) + int'(wr_en_2) + int'(done);
        if (busy === 1'b1) n_busy++;
        if (busy === 1'b1 && prev_busy !== 1'b1) rise_q.push_back(cyc);
        if (rd_en === 1'b1) n_rd++;
        if (wr_en_1 === 1'b1) n_w1++;
        if (wr_en_2 === 1'b1) n_w2++;
        if (done === 1'b1) begin
          n_done++;
          done_q.push_back(cyc);
        end
        checks++;
        if (n > 1) begin
          failures++;
          $display("FAIL strobe_onehot: cycle %0d got %0d strobes high, want at most 1", cyc, n);
        end else if (n == 1) begin
          obs.kind = rd_en ? EV_RD : (slice_load ? EV_LD : (wr_en_1 ? EV_C1 :
                     (wr_en_2 ? EV_W2 : EV_DN)));
          obs.busy = busy;
          obs.z    = cnt64_value;
          obs.lane = cnt24_value;
          obs.addr = rd_en ? rd_addr : 6'd0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: cycle %0d got kind=%0d z=%0d lane=%0d, want none",
                     cyc, obs.kind, obs.z, obs.lane);
          end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
              failures++;
              $display("FAIL strobe_event: cycle %0d got kind=%0d busy=%0d z=%0d lane=%0d addr=%0d, want kind=%0d busy=%0d z=%0d lane=%0d addr=%0d",
                       cyc, obs.kind, obs.busy, obs.z, obs.lane, obs.addr,
                       want.kind, want.busy, want.z, want.lane, want.addr);
            end
          end
        end
      end
      prev_busy = busy;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;  // start held during reset must be ignored
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, slice_load, wr_en_1, wr_en_2, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 00000", {rd_en, slice_load, wr_en_1, wr_en_2, done});
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if ({rd_addr, cnt64_value, cnt24_value} !== 17'd0) begin
      failures++;
      $display("FAIL reset_counters: got addr=%0d z=%0d lane=%0d want 0 0 0", rd_addr, cnt64_value, cnt24_value);
    end
    #1;
    rst_n  = 1'b1;
    start  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, rd_en, done} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b rd_en=%b done=%b want 0 0 0", busy, rd_en, done);
    end
  endtask

  task automatic test_full_pass();
    int exp_rise;
    bit seen;
    @(posedge clk); #1;
    reset_stats();
    push_pass(-1, -1);
    start    = 1'b1;
    exp_rise = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 3500 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (n_done != 0);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL full_done_timeout: got no done within 3500 cycles, want one");
    end
    checks++;
    if (rise_q.size() != 1 || rise_q[0] != exp_rise) begin
      failures++;
      $display("FAIL full_start_latency: got %0d rises first=%0d want 1 rise at %0d",
               rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, exp_rise);
    end
    checks++;
    if (n_busy != 3328) begin
      failures++;
      $display("FAIL full_busy_cycles: got %0d want 3328", n_busy);
    end
    checks++;
    if (n_done != 1 || done_q[0] != exp_rise + 3328) begin
      failures++;
      $display("FAIL full_done_pulse: got %0d pulses first at %0d want 1 at %0d",
               n_done, (done_q.size() > 0) ? done_q[0] : -1, exp_rise + 3328);
    end
    checks++;
    if (n_rd != 64 || n_w1 != 1600 || n_w2 != 1600) begin
      failures++;
      $display("FAIL full_strobe_counts: got rd=%0d w1=%0d w2=%0d want 64 1600 1600", n_rd, n_w1, n_w2);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_scoreboard_left: got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || cnt64_value !== 6'd63 || cnt24_value !== 5'd24) begin
      failures++;
      $display("FAIL full_final_hold: got busy=%b z=%0d lane=%0d want 0 63 24", busy, cnt64_value, cnt24_value);
    end
  endtask

  task automatic test_back_to_back();
    int exp_rise;
    int d0;
    int r1;
    bit seen;
    @(posedge clk); #1;
    reset_stats();
    push_pass(-1, -1);
    push_pass(-1, -1);
    start    = 1'b1;
    exp_rise = cyc + 1;
    repeat (4000) @(negedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 3500 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (n_done >= 2);
    end
    repeat (6) @(negedge clk);
    #1;
    d0 = (done_q.size() > 0) ? done_q[0] : -1;
    r1 = (rise_q.size() > 1) ? rise_q[1] : -1;
    checks++;
    if (n_done != 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
    checks++;
    if (d0 != exp_rise + 3328) begin
      failures++;
      $display("FAIL b2b_first_done: got %0d want %0d", d0, exp_rise + 3328);
    end
    checks++;
    if (rise_q.size() != 2 || r1 != d0 + 2) begin
      failures++;
      $display("FAIL b2b_second_start: got %0d rises second=%0d want 2 with second at %0d",
               rise_q.size(), r1, d0 + 2);
    end
    checks++;
    if (n_busy != 6656) begin
      failures++;
      $display("FAIL b2b_busy_cycles: got %0d want 6656", n_busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_scoreboard_left: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_pass();
    bit found;
    @(posedge clk); #1;
    reset_stats();
    push_pass(17, 9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      found = (wr_en_1 === 1'b1 && cnt64_value == 6'd17 && cnt24_value == 5'd9);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrst_reach: got no CALC at z=17 lane=9 within 1200 cycles, want it");
    end
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, slice_load, cnt64_value, cnt24_value, wr_en_1, wr_en_2, busy, done} !== 23'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got busy=%b z=%0d lane=%0d addr=%0d strobes=%b want all 0",
               busy, cnt64_value, cnt24_value, rd_addr, {rd_en, slice_load, wr_en_1, wr_en_2, done});
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, rd_en, slice_load, wr_en_1, wr_en_2, done} !== 6'd0) begin
      failures++;
      $display("FAIL midrst_idle_after: got busy=%b strobes=%b want 0 00000",
               busy, {rd_en, slice_load, wr_en_1, wr_en_2, done});
    end
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL midrst_no_done: got %0d done pulses want 0", n_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_scoreboard_left: got %0d pending want 0", exp_q.size());
    end
    // A fresh start must begin again at slice 0, lane 0.
    @(posedge clk); #1;
    push_pass(0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = (wr_en_1 === 1'b1);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL restart_first_calc: got no wr_en_1 within 10 cycles, want one");
    end
    #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart_scoreboard_left: got %0d pending want 0", exp_q.size());
    end
  endtask

`ifdef ROTATE_CTRL_STALL_EN
  task automatic test_stall();
    int exp_rise;
    int d0;
    bit found;
    bit seen;
    @(posedge clk); #1;
    reset_stats();
    push_pass(-1, -1);
    start    = 1'b1;
    exp_rise = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = (wr_en_2 === 1'b1 && cnt64_value == 6'd3 && cnt24_value == 5'd6);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stall_reach: got no WRITE at z=3 lane=6 within 400 cycles, want it");
    end
    // Raise stall on the edge that enters CALC(3,7) and hold it 5 cycles.
    @(posedge clk); #1;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rd_en, slice_load, wr_en_1, wr_en_2} !== 4'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_strobes: stall cycle %0d got strobes=%b busy=%b want 0000 1",
                 k, {rd_en, slice_load, wr_en_1, wr_en_2}, busy);
      end
      checks++;
      if (cnt64_value !== 6'd3 || cnt24_value !== 5'd7) begin
        failures++;
        $display("FAIL stall_counters: stall cycle %0d got z=%0d lane=%0d want 3 7", k, cnt64_value, cnt24_value);
      end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 3500 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (n_done != 0);
    end
    repeat (4) @(negedge clk);
    #1;
    d0 = (done_q.size() > 0) ? done_q[0] : -1;
    checks++;
    if (n_busy != 3333) begin
      failures++;
      $display("FAIL stall_busy_cycles: got %0d want 3333", n_busy);
    end
    checks++;
    if (n_done != 1 || d0 != exp_rise + 3333) begin
      failures++;
      $display("FAIL stall_done_pulse: got %0d pulses first at %0d want 1 at %0d", n_done, d0, exp_rise + 3333);
    end
    checks++;
    if (n_w1 != 1600) begin
      failures++;
      $display("FAIL stall_w1_count: got %0d want 1600", n_w1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_scoreboard_left: got %0d pending want 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
`ifdef ROTATE_CTRL_STALL_EN
    stall = 1'b0;
`endif
    reset_stats();
    fork
      monitor();
    join_none
    test_reset();
    test_full_pass();
    test_back_to_back();
    test_reset_mid_pass();
`ifdef ROTATE_CTRL_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_ctrl.md
ROTATE_CTRL -- requirements
Module: rotate_ctrl

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low, with ports named clk and rst_n.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to run one full rotate pass; sampled only in IDLE.
- rd_en  output  1  read strobe to the slice source memory.
- rd_addr  output  6  slice index being read.
- slice_load  output  1  capture strobe for the rotate datapath slice input, one cycle after rd_en.
- cnt64_value  output  6  current slice index (z) to the rotate datapath.
- cnt24_value  output  5  current lane index, 0..24, to the rotate datapath.
- wr_en_1  output  1  lane-index calculation phase strobe.
- wr_en_2  output  1  lane write phase strobe.
- busy  output  1  pass in progress.
- done  output  1  single-cycle pass-complete pulse.
- stall  input  1  freeze request; present only when ROTATE_CTRL_STALL_EN is defined.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, READ, LOAD, CALC, WRITE, DONE.
REQ-004 IDLE with start=1 SHALL go to READ and clear cnt64_value and cnt24_value; with start=0 it SHALL stay in IDLE.
REQ-005 READ SHALL assert rd_en=1 with rd_addr=cnt64_value and go to LOAD next cycle, allowing one cycle of memory read latency.
REQ-006 LOAD SHALL assert slice_load=1 and go to CALC.
REQ-007 CALC SHALL assert wr_en_1=1 and go to WRITE.
REQ-008 WRITE SHALL assert wr_en_2=1.
- If cnt24_value<24: increment cnt24_value and go to CALC.
- If cnt24_value=24 and cnt64_value<63: clear cnt24_value, increment cnt64_value, go to READ.
- If cnt24_value=24 and cnt64_value=63: go to DONE.
REQ-009 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; counters SHALL hold their final values (63, 24) until the next start.
REQ-010 rd_en, slice_load, wr_en_1, wr_en_2 and done SHALL each be a decode of the registered state only, mutually exclusive, and never high in IDLE.
REQ-011 busy SHALL be 1 in READ, LOAD, CALC and WRITE, and 0 in IDLE and DONE.
REQ-012 Per-slice cost SHALL be 52 cycles (READ + LOAD + 25×(CALC+WRITE)); a full pass SHALL keep busy high for exactly 3328 cycles, with done in the following cycle.
REQ-013 start SHALL be ignored outside IDLE, including in DONE; a start held high through DONE SHALL launch a new pass from the IDLE cycle that follows.
REQ-014 cnt24_value SHALL never exceed 24, and cnt64_value SHALL never wrap during a pass.

Reset
REQ-015 On a clk edge with rst_n=0, the block SHALL enter IDLE and set every output to 0: rd_en, rd_addr, slice_load, cnt64_value, cnt24_value, wr_en_1, wr_en_2, busy, done.
REQ-016 Reset asserted mid-pass SHALL abort the pass immediately, with no done pulse; the first cycle after release SHALL be IDLE.
REQ-017 Reset SHALL take priority over start and stall.

Configuration
REQ-018 When the macro ROTATE_CTRL_STALL_EN is defined, the block SHALL have the stall input, with this behaviour:
- While stall=1 in READ, LOAD, CALC or WRITE, state and counters SHALL hold.
- rd_en, slice_load, wr_en_1 and wr_en_2 SHALL be forced to 0.
- busy SHALL stay 1.
- Stall SHALL have no effect in IDLE or DONE.
- When stall is released, the held state's strobe SHALL be issued once.
REQ-019 When ROTATE_CTRL_STALL_EN is not defined, the stall port SHALL be absent and the FSM SHALL never pause; pass length SHALL be fixed per REQ-012.

Verification
REQ-020 Reset then a 1-cycle start pulse -> 64 rd_en pulses with rd_addr 0..63 in order, 1600 wr_en_1 and 1600 wr_en_2 pulses, busy high 3328 cycles, one done pulse, then IDLE.
REQ-021 Within one slice -> pattern READ, LOAD, then alternating wr_en_1/wr_en_2 with cnt24_value 0,0,1,1,...,24,24; cnt64_value constant throughout the slice.
REQ-022 start held high for 4000 cycles -> second pass begins in the cycle after IDLE following done, and no start is accepted mid-pass.
REQ-023 rst_n=0 for one cycle when cnt64_value=17 and cnt24_value=9 -> all outputs 0 on the next cycle, no done pulse, and a fresh start restarts from slice 0, lane 0.
REQ-024 With ROTATE_CTRL_STALL_EN defined, stall=1 for 5 cycles during CALC at (z=3, lane=7) -> wr_en_1 low for those 5 cycles, counters hold at (3,7), busy stays 1, and the pass completes in 3333 busy cycles.
REQ-025 Without ROTATE_CTRL_STALL_EN, a compile-time check SHALL confirm that no stall port is present and that busy length is 3328.
